vertical_fir_accumulator: RTL
=============================

Name: vertical_fir_accumulator

Overview:
- Parametrised multi-tap vertical interpolation accumulator for the backend scaler path; successor to the fixed 4-channel, 6-state line accumulator.
- Accepts one source row per tap over a valid/ready handshake and multiplies all NUM_CH pixels by a shared signed per-tap coefficient.
- Accumulates with a rounding bias, then clips each channel to unsigned DATA_W and presents the result on a valid/ready output.
- Coefficients come from the upstream coefficient generator; tap count and widths are parameters, not hard-wired states.

Parameters:
- NUM_CH, 4, pixels processed in parallel per tap.
- DATA_W, 8, unsigned pixel width in and out.
- COEF_W, 10, signed two's-complement coefficient width.
- FRAC_BITS, 8, coefficient fractional bits; unity gain = 1<<FRAC_BITS.
- NUM_TAPS, 6, taps per output group (2..16).
- ACC_W, 22, signed accumulator width per channel; must be >= DATA_W+COEF_W+clog2(NUM_TAPS)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new output group; sampled only in IDLE.
- tap_valid  in  1  tap_data/tap_coef valid.
- tap_ready  out  1  accumulator accepts a tap this cycle.
- tap_data  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- tap_coef  in  COEF_W  signed coefficient for this tap, shared by all channels.
- out_valid  out  1  out_data holds a finished group.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  NUM_CH*DATA_W  clipped results, same packing as tap_data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, synchronous and active-high, has priority over everything including mid-group. Afterwards: state=IDLE, tap count=0, every accumulator = 1<<(FRAC_BITS-1), tap_ready=0, out_valid=0, out_data=0, busy=0.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE: tap_ready=0. start=1 loads every accumulator with the rounding bias 1<<(FRAC_BITS-1), clears the tap count and moves to ACCUM.
- ACCUM: tap_ready=1. On each accepted tap (tap_valid & tap_ready): acc[k] += sext(tap_coef) * zext(tap_data[k]), full ACC_W signed arithmetic, and the tap count increments. tap_valid=0 holds all state.
- Acceptance of tap number NUM_TAPS-1 registers the clipped results into out_data and moves to HOLD. out_valid rises the next cycle, so latency is 1 cycle from the last tap handshake.
- Clip per channel: r = acc >>> FRAC_BITS (arithmetic shift). r<0 gives 0; r>2^DATA_W-1 gives 2^DATA_W-1; otherwise r[DATA_W-1:0].
- HOLD: tap_ready=0 and out_valid=1. out_data is stable until out_valid & out_ready.
- On the HOLD handshake: out_valid falls the next cycle. If start=1 in the same cycle, the accumulators reload the bias and the FSM goes straight to ACCUM (back-to-back groups, no IDLE bubble). Otherwise it returns to IDLE.
- start is ignored in ACCUM, and ignored in HOLD without a handshake.
- tap_valid outside ACCUM is ignored, with no accumulation.
- out_data keeps its last value after out_valid falls.
- Intermediate accumulator values never wrap for legal parameters. The ACC_W rule guarantees this; overflow is not checked.

Optional Feature:
- Macro VFIR_CLIP_STATS_EN.
- When defined: adds output port clip_count [15:0]. It increments by the number of channels clipped (low or high) in each registered group and saturates at 16'hFFFF. It is cleared by reset only.
- When undefined: the port and its logic are absent, with no change to any other behaviour.

Test Plan:
- Reset/idle: hold reset 3 cycles, release with start=0 and tap_valid=1 -> tap_ready=0, out_valid=0, out_data=0, busy=0. Assert reset mid-ACCUM after 3 taps -> IDLE next cycle and no output.
- Unity passthrough (defaults): start; six taps with coefs {0,0,256,0,0,0}, tap 2 data=all 8'd100, other taps 8'd200 -> one cycle after the 6th tap, out_valid=1 and every channel=100.
- Interpolation with rounding: coefs {-7,30,110,110,30,-7} (sum 266), all data 8'd255 -> (255*266+128)>>8 = 265, clipped to 255 on all channels. Same coefs with all data 8'd10 -> (2660+128)>>8 = 10.
- Negative clip: coefs {-512,0,0,0,0,0}, data 8'd255, other taps 0 -> all channels 0. With VFIR_CLIP_STATS_EN, clip_count += 4.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles -> out_data stable, tap_ready=0, incoming taps ignored. Then out_ready=1 with start=1 -> next cycle ACCUM, tap_ready=1, second group completes correctly.
- Handshake gaps: drop tap_valid for random cycles between taps -> same result as the gap-free run; exactly NUM_TAPS handshakes are consumed per group.

Source files
------------

// File: rtl/vertical_fir_accumulator_if.sv
// Tap-input and result-output handshake bundle for vertical_fir_accumulator.
// master drives taps and consumes results; slave is the accumulator.
interface vertical_fir_accumulator_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 10
);
    logic                       tap_valid;
    logic                       tap_ready;
    logic [NUM_CH*DATA_W-1:0]   tap_data;
    logic [COEF_W-1:0]          tap_coef;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_CH*DATA_W-1:0]   out_data;

    modport master (
        output tap_valid, tap_data, tap_coef, out_ready,
        input  tap_ready, out_valid, out_data
    );

    modport slave (
        input  tap_valid, tap_data, tap_coef, out_ready,
        output tap_ready, out_valid, out_data
    );
endinterface

// File: rtl/vertical_fir_accumulator.sv
// Multi-tap vertical interpolation accumulator with rounding and unsigned clip.
// Optional macro VFIR_CLIP_STATS_EN adds a saturating clip_count output.
module vertical_fir_accumulator #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COEF_W    = 10,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned NUM_TAPS  = 6,
    parameter int unsigned ACC_W     = 22
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    vertical_fir_accumulator_if.slave     bus
`ifdef VFIR_CLIP_STATS_EN
    ,
    output logic [15:0]                   clip_count
`endif
);
    localparam int unsigned CNT_W = $clog2(NUM_TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(1 << (FRAC_BITS - 1));

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_acc [NUM_CH];
    logic                       r_tap_ready;
    logic                       r_out_valid;
    logic                       r_busy;
    logic [NUM_CH*DATA_W-1:0]   r_out_data;

    logic signed [ACC_W-1:0]    w_coef_ext;
    logic signed [ACC_W-1:0]    w_acc_nxt [NUM_CH];
    logic signed [ACC_W-1:0]    w_shift   [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]   w_clip;
    logic [NUM_CH-1:0]          w_clipped;
    logic                       w_tap_hs;
    logic                       w_out_hs;
    logic                       w_last;

    assign w_tap_hs = bus.tap_valid & r_tap_ready;
    assign w_out_hs = r_out_valid & bus.out_ready;
    assign w_last   = w_tap_hs & (r_cnt == LAST_TAP);

    // MAC per channel followed by round-shift and clip to unsigned DATA_W
    always_comb begin
        w_coef_ext = {{(ACC_W-COEF_W){bus.tap_coef[COEF_W-1]}}, bus.tap_coef};
        w_clip     = '0;
        w_clipped  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_acc_nxt[k] = r_acc[k] + w_coef_ext *
                $signed({{(ACC_W-DATA_W){1'b0}}, bus.tap_data[k*DATA_W +: DATA_W]});
            w_shift[k] = w_acc_nxt[k] >>> FRAC_BITS;
            if (w_shift[k][ACC_W-1]) begin
                w_clip[k*DATA_W +: DATA_W] = '0;
                w_clipped[k]               = 1'b1;
            end else if (|w_shift[k][ACC_W-2:DATA_W]) begin
                w_clip[k*DATA_W +: DATA_W] = '1;
                w_clipped[k]               = 1'b1;
            end else begin
                w_clip[k*DATA_W +: DATA_W] = w_shift[k][DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tap_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
            for (int k = 0; k < NUM_CH; k++) r_acc[k] <= BIAS;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= ACCUM;
                        r_cnt       <= '0;
                        r_tap_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        for (int k = 0; k < NUM_CH; k++) r_acc[k] <= BIAS;
                    end
                end
                ACCUM: begin
                    if (w_tap_hs) begin
                        for (int k = 0; k < NUM_CH; k++) r_acc[k] <= w_acc_nxt[k];
                        if (w_last) begin
                            r_state     <= HOLD;
                            r_out_data  <= w_clip;
                            r_tap_ready <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // start alongside the output handshake chains straight into the next group
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        if (start) begin
                            r_state     <= ACCUM;
                            r_cnt       <= '0;
                            r_tap_ready <= 1'b1;
                            for (int k = 0; k < NUM_CH; k++) r_acc[k] <= BIAS;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_tap_ready <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tap_ready = r_tap_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = r_busy;

`ifdef VFIR_CLIP_STATS_EN
    logic [15:0] r_clip_count;
    logic [16:0] w_clip_sum;

    always_comb begin
        w_clip_sum = {1'b0, r_clip_count};
        for (int k = 0; k < NUM_CH; k++) w_clip_sum = w_clip_sum + 17'(w_clipped[k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clip_count <= '0;
        end else if (r_state == ACCUM && w_last) begin
            r_clip_count <= w_clip_sum[16] ? 16'hFFFF : w_clip_sum[15:0];
        end
    end

    assign clip_count = r_clip_count;
`endif
endmodule
